// File: rtl/idma_desc64_reader_gen.sv
// rtl/idma_desc64_reader_gen.sv - width-generic desc64 descriptor reader; option macro IDMA_DESC64_READER_GEN_ERR_EN
package idma_desc64_reader_gen_pkg;
    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_64_t;
endpackage

module idma_desc64_reader_gen #(
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned DescWidth    = 256,
    parameter type         axi_r_chan_t = idma_desc64_reader_gen_pkg::r_chan_64_t,
    parameter type         descriptor_t = logic [255:0]
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  axi_r_chan_t r_chan_i,
    input  logic        r_valid_i,
    output logic        r_ready_o,
    output descriptor_t desc_o,
    output logic        desc_valid_o,
    input  logic        desc_ready_i,
    output logic        desc_err_o,
    output logic        irq_o,
    output logic        irq_valid_o,
    output logic [63:0] next_addr_o,
    output logic        next_addr_valid_o,
    output logic        proto_err_o,
    output logic        inflight_o
);
    localparam int unsigned Beats    = DescWidth / DataWidth;
    localparam int unsigned CntW     = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned NextBeat = (128 + DataWidth - 1) / DataWidth - 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(Beats - 1);
    localparam logic [CntW-1:0] NextIdx = CntW'(NextBeat);

    if (DescWidth != 256) begin : g_bad_desc_width
        $error("idma_desc64_reader_gen: DescWidth must be 256");
    end
    if (!(DataWidth == 32 || DataWidth == 64 || DataWidth == 128 || DataWidth == 256))
    begin : g_bad_data_width
        $error("idma_desc64_reader_gen: DataWidth must be 32, 64, 128 or 256");
    end

    typedef enum logic {
        ST_FILL,
        ST_DISCARD
    } state_e;

    state_e                          state_q;
    logic [CntW-1:0]                 cnt_q;
    logic [Beats-1:0][DataWidth-1:0] asm_q;
    logic [Beats-1:0][DataWidth-1:0] asm_d;
    logic [DescWidth-1:0]            desc_d;
    logic [CntW-1:0]                 slot;
    descriptor_t                     desc_q;
    logic                            desc_valid_q;
    logic                            desc_err_q;
    logic                            err_q;
    logic                            irq_q;
    logic                            irq_valid_q;
    logic [63:0]                     next_q;
    logic                            next_valid_q;
    logic                            proto_q;
    logic                            is_final;
    logic                            out_free;
    logic                            beat_hs;
    logic                            err_now;

    // Beat 0 lands in the top slot so the first beat carries the MSBs.
    assign slot     = LastIdx - cnt_q;
    assign is_final = (cnt_q == LastIdx);
    assign out_free = !desc_valid_q || desc_ready_i;

    always_comb begin
        asm_d       = asm_q;
        asm_d[slot] = r_chan_i.data;
    end
    assign desc_d = asm_d;

    // Only a beat that can complete (or abort) a descriptor waits on the output stage.
    assign r_ready_o = (state_q == ST_DISCARD) || !(is_final || r_chan_i.last) || out_free;
    assign beat_hs   = r_valid_i && r_ready_o;

`ifdef IDMA_DESC64_READER_GEN_ERR_EN
    assign err_now    = err_q || (r_chan_i.resp != 2'b00);
    assign desc_err_o = desc_err_q;
`else
    logic unused_err;
    assign err_now    = 1'b0;
    assign desc_err_o = 1'b0;
    assign unused_err = ^{r_chan_i.resp, desc_err_q, err_q};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_FILL;
            cnt_q        <= '0;
            asm_q        <= '0;
            desc_q       <= '0;
            desc_valid_q <= 1'b0;
            desc_err_q   <= 1'b0;
            err_q        <= 1'b0;
            irq_q        <= 1'b0;
            irq_valid_q  <= 1'b0;
            next_q       <= '0;
            next_valid_q <= 1'b0;
            proto_q      <= 1'b0;
        end else begin
            irq_valid_q  <= 1'b0;
            next_valid_q <= 1'b0;
            proto_q      <= 1'b0;
            if (desc_valid_q && desc_ready_i) begin
                desc_valid_q <= 1'b0;
            end
            if (beat_hs) begin
                if (state_q == ST_DISCARD) begin
                    if (r_chan_i.last) begin
                        state_q <= ST_FILL;
                    end
                end else if (is_final) begin
                    desc_q       <= descriptor_t'(desc_d);
                    desc_valid_q <= 1'b1;
                    desc_err_q   <= err_now;
                    cnt_q        <= '0;
                    err_q        <= 1'b0;
                    if (!r_chan_i.last) begin
                        state_q <= ST_DISCARD;
                        proto_q <= 1'b1;
                    end
                end else if (r_chan_i.last) begin
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    proto_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                    asm_q <= asm_d;
                    err_q <= err_now;
                end
                // Sideband is early information about a descriptor that is still live.
                if (state_q == ST_FILL && (is_final || !r_chan_i.last) && !err_now) begin
                    if (cnt_q == '0) begin
                        irq_q       <= desc_d[224];
                        irq_valid_q <= 1'b1;
                    end
                    if (cnt_q == NextIdx) begin
                        next_q       <= desc_d[191:128];
                        next_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign desc_o            = desc_q;
    assign desc_valid_o      = desc_valid_q;
    assign irq_o             = irq_q;
    assign irq_valid_o       = irq_valid_q;
    assign next_addr_o       = next_q;
    assign next_addr_valid_o = next_valid_q;
    assign proto_err_o       = proto_q;
    assign inflight_o        = (cnt_q != '0) || desc_valid_q || (state_q == ST_DISCARD);

endmodule
